// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: accepts characters over valid/ready and
// serialises START, DATA, optional PARITY and STOP with internally timed bits.
module uart_tx_frame_ctrl #(
    parameter int CHAR_LENGTH = 8,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   pclk,
    input  logic                   areset,
    input  logic [DIV_WIDTH-1:0]   cfg_baud_div,
    input  logic [3:0]             cfg_oversampling,
    input  logic [3:0]             cfg_uart_type,
    input  logic [1:0]             cfg_stop_bit,
    input  logic                   cfg_parity_en,
    input  logic                   cfg_parity_odd,
    input  logic                   cfg_msb_first,
    input  logic                   tx_valid,
    input  logic [CHAR_LENGTH-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [3:0]             state,
    output logic                   frame_done,
    output logic                   cfg_err
);
    localparam int BW = DIV_WIDTH + 4;
    localparam int CW = DIV_WIDTH + 5;

    typedef enum logic [3:0] {
        DATA0       = 4'd0,
        DATA1       = 4'd1,
        DATA2       = 4'd2,
        DATA3       = 4'd3,
        DATA4       = 4'd4,
        DATA5       = 4'd5,
        DATA6       = 4'd6,
        DATA7       = 4'd7,
        PARITY      = 4'd8,
        STOP_1BIT   = 4'd9,
        STOP_1_5BIT = 4'd10,
        STOP_2BIT   = 4'd11,
        START       = 4'd13,
        IDLE        = 4'd14,
        RESET       = 4'd15
    } uart_fsm_state_e;

    uart_fsm_state_e        cur;
    uart_fsm_state_e        nxt_state;
    uart_fsm_state_e        stop_state;
    logic [CHAR_LENGTH-1:0] data_sh;
    logic [CHAR_LENGTH-1:0] mask;
    logic [BW-1:0]          bt_sh;
    logic [BW-1:0]          bt_new;
    logic [3:0]             n_sh;
    logic                   par_en_sh;
    logic                   par_odd_sh;
    logic                   msb_sh;
    logic [1:0]             stop_sh;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          nxt_cnt;
    logic [CW-1:0]          stop_len;
    logic [3:0]             nxt_idx;
    logic [3:0]             bit_pos;
    logic                   data_bit;
    logic                   parity_bit;
    logic                   last_data;
    logic                   is_stop;
    logic                   nxt_tx;
    logic                   tx_r;
    logic                   done_r;

    always_comb begin
        cfg_err = (cfg_baud_div == '0)
               || !(cfg_oversampling inside {4'd2, 4'd4, 4'd6, 4'd8})
               || !(cfg_uart_type inside {[4'd5:4'd8]})
               || (cfg_stop_bit == 2'd2);
        bt_new = BW'(cfg_baud_div) * BW'(cfg_oversampling);
        mask = '0;
        for (int k = 0; k < CHAR_LENGTH; k++) begin
            if (k < int'(cfg_uart_type)) mask[k] = 1'b1;
        end
    end

    // Next-state, next-tx and counter reload for the state that follows the current one.
    always_comb begin
        is_stop = (cur == STOP_1BIT) || (cur == STOP_1_5BIT) || (cur == STOP_2BIT);
        case (stop_sh)
            2'd0: begin
                stop_state = STOP_1_5BIT;
                stop_len   = {1'b0, bt_sh} + {2'b00, bt_sh[BW-1:1]};
            end
            2'd3: begin
                stop_state = STOP_2BIT;
                stop_len   = {bt_sh, 1'b0};
            end
            default: begin
                stop_state = STOP_1BIT;
                stop_len   = {1'b0, bt_sh};
            end
        endcase
        nxt_idx   = (cur == START) ? 4'd0 : ({1'b0, cur[2:0]} + 4'd1);
        bit_pos   = msb_sh ? (n_sh - 4'd1 - nxt_idx) : nxt_idx;
        data_bit  = 1'b0;
        for (int k = 0; k < CHAR_LENGTH; k++) begin
            if (bit_pos == 4'(k)) data_bit = data_sh[k];
        end
        parity_bit = (^data_sh) ^ par_odd_sh;
        last_data  = ({1'b0, cur[2:0]} == (n_sh - 4'd1));
        nxt_state  = IDLE;
        nxt_tx     = 1'b1;
        nxt_cnt    = {1'b0, bt_sh};
        if (cur == START) begin
            nxt_state = DATA0;
            nxt_tx    = data_bit;
        end else if (cur == PARITY) begin
            nxt_state = stop_state;
            nxt_cnt   = stop_len;
        end else if (!is_stop && !cur[3]) begin
            if (!last_data) begin
                nxt_state = uart_fsm_state_e'(nxt_idx);
                nxt_tx    = data_bit;
            end else if (par_en_sh) begin
                nxt_state = PARITY;
                nxt_tx    = parity_bit;
            end else begin
                nxt_state = stop_state;
                nxt_cnt   = stop_len;
            end
        end
    end

    // Frame sequencer; frame_done is armed one cycle ahead so it lands on the last STOP cycle.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            cur        <= RESET;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
            cnt        <= '0;
            data_sh    <= '0;
            bt_sh      <= '0;
            n_sh       <= '0;
            par_en_sh  <= 1'b0;
            par_odd_sh <= 1'b0;
            msb_sh     <= 1'b0;
            stop_sh    <= 2'd1;
        end else begin
            done_r <= 1'b0;
            case (cur)
                RESET: begin
                    cur  <= IDLE;
                    tx_r <= 1'b1;
                end
                IDLE: begin
                    tx_r <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        data_sh    <= tx_data & mask;
                        bt_sh      <= bt_new;
                        n_sh       <= cfg_uart_type;
                        par_en_sh  <= cfg_parity_en;
                        par_odd_sh <= cfg_parity_odd;
                        msb_sh     <= cfg_msb_first;
                        stop_sh    <= cfg_stop_bit;
                        cnt        <= {1'b0, bt_new};
                        cur        <= START;
                        tx_r       <= 1'b0;
                    end
                end
                default: begin
                    if (cnt <= CW'(1)) begin
                        cur  <= nxt_state;
                        tx_r <= nxt_tx;
                        cnt  <= nxt_cnt;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (is_stop && (cnt == CW'(2))) done_r <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx_ready   = (cur == IDLE) && !cfg_err;
    assign busy       = !((cur == IDLE) || (cur == RESET));
    assign state      = cur;
    assign tx         = tx_r;
    assign frame_done = done_r;

endmodule
